serial_add_ctrl: RTL and testbench

- Bit-serial adder controller: sequences a single 1-bit full-adder cell over a WIDTH-bit operand pair, one bit per clock, LSB first.
- Reuses the team's 1-bit full-adder cell (inputs a, b, c; outputs sum, cout) as its only arithmetic resource.
- Trades latency for area against the parallel ripple-carry adder.
- Start/busy/done handshake toward the requesting block.

---
 rtl/serial_add_ctrl_if.sv | 25 ++
 rtl/serial_add_ctrl.sv | 112 +++++++++++
 tb/tb_serial_add_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done handshake bundle for the bit-serial adder controller.
// The sub request line exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one 1-bit full-adder cell stepped LSB first over WIDTH bits.
// Optional subtract mode (a - b) is enabled by defining SERIAL_ADD_SUB_EN.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (a & c) | (b & c);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  logic             c_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sb_load;
  logic             c_load;

  fa_cell u_fa (
    .a    (sa_reg[0]),
    .b    (sb_reg[0]),
    .c    (c_reg),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1, so the adder cell itself is unchanged.
  assign sb_load = bus.sub ? ~bus.b : bus.b;
  assign c_load  = bus.sub ? 1'b1 : bus.cin;
`else
  assign sb_load = bus.b;
  assign c_load  = bus.cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      c_reg     <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            sa_reg    <= bus.a;
            sb_reg    <= sb_load;
            c_reg     <= c_load;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          // Result bits enter at the MSB so after WIDTH steps bit 0 lands at sum[0].
          sa_reg  <= sa_reg >> 1;
          sb_reg  <= sb_reg >> 1;
          sum_reg <= {fa_sum, sum_reg[WIDTH-1:1]};
          c_reg   <= fa_cout;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH - 1)) begin
            cout_reg  <= fa_cout;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: arithmetic/timeline reference model,
// per-cycle compare process, directed literal cases and randomized traffic.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  bit   chk_en;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles since the accepted start (0 = idle) and the
  // arithmetic result a + b + cin, published when the done cycle is reached.
  int           m_cyc;
  logic [W-1:0] m_sum;
  logic         m_cout;
  logic [W:0]   m_pend;

  initial begin
    m_cyc  = 0;
    m_sum  = '0;
    m_cout = 1'b0;
    m_pend = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_cyc  = 0;
        m_sum  = '0;
        m_cout = 1'b0;
      end else if (m_cyc == 0) begin
        if (bus.start === 1'b1) begin
          m_pend = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin};
`ifdef SERIAL_ADD_SUB_EN
          if (bus.sub === 1'b1)
            m_pend = {1'b0, bus.a} + {1'b0, ~bus.b} + {{W{1'b0}}, 1'b1};
`endif
          m_cyc = 1;
        end
      end else if (m_cyc == W + 1) begin
        m_cyc = 0;
      end else begin
        m_cyc++;
        if (m_cyc == W + 1) {m_cout, m_sum} = m_pend;
      end
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy", 32'(bus.busy), 32'(m_cyc >= 1 && m_cyc <= W));
        check("done", 32'(bus.done), 32'(m_cyc == W + 1));
        if (m_cyc == 0 || m_cyc == W + 1) begin
          check("sum", 32'(bus.sum), 32'(m_sum));
          check("cout", 32'(bus.cout), 32'(m_cout));
        end
      end
    end
  end

  task automatic drive_idle();
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = 1'b0;
`endif
  endtask

  // One directed operation; called at a negedge while the DUT is idle or in DONE.
  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input logic [W-1:0] exp_sum,
                       input logic exp_cout);
    int busy_n;
    int done_k;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = sub;
`else
    if (sub) $display("[TB] %s: subtract mode not built, running as add", name);
`endif
    busy_n = 0;
    done_k = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0;
        bus.a     = 8'hAA;
        bus.b     = 8'hAA;
        bus.cin   = ~cin;
      end
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) begin
        done_k = k;
        break;
      end
    end
    check({name, "_done_cycle"}, 32'(done_k), 32'(W + 1));
    check({name, "_busy_cycles"}, 32'(busy_n), 32'(W));
    check({name, "_sum"}, 32'(bus.sum), 32'(exp_sum));
    check({name, "_cout"}, 32'(bus.cout), 32'(exp_cout));
    $display("[TB] op %s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d done@+%0d",
             name, a, b, cin, sub, bus.sum, bus.cout, done_k);
  endtask

  initial begin
    int dones;
    int done_at[2];
    tests  = 0;
    fails  = 0;
    chk_en = 1'b0;
    rst    = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_sum", 32'(bus.sum), 32'd0);
    check("reset_cout", 32'(bus.cout), 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;

    do_op("0F+01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0);
    do_op("FF+01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    do_op("00+00+1", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);

    // start held for 20 edges: exactly two operations complete.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    bus.cin   = 1'b0;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 19) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        if (dones < 2) done_at[dones] = k + 1;
        dones++;
        check("held_sum", 32'(bus.sum), 32'h46);
      end
    end
    check("held_done_count", 32'(dones), 32'd2);
    if (dones == 2) begin
      check("held_done1", 32'(done_at[0]), 32'd9);
      check("held_done2", 32'(done_at[1]), 32'd19);
    end
    $display("[TB] op held-start 12+34 -> %0d done pulses", dones);
    drive_idle();
    repeat (3) @(negedge clk);

    // Reset at T+4 of 80+80: outputs clear, no done pulse follows.
    bus.start = 1'b1;
    bus.a     = 8'h80;
    bus.b     = 8'h80;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_sum", 32'(bus.sum), 32'd0);
    check("midrst_cout", 32'(bus.cout), 32'd0);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    $display("[TB] op reset mid 80+80 -> sum=%h cout=%0d", bus.sum, bus.cout);
    do_op("80+80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);

`ifdef SERIAL_ADD_SUB_EN
    do_op("05-07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
    do_op("07-05", 8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1);
`endif

    // Random traffic: start, operands and rare resets change every cycle.
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      bus.start = 1'($urandom_range(0, 1));
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.cin   = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADD_SUB_EN
      bus.sub   = 1'($urandom_range(0, 1));
`endif
      rst = ($urandom_range(0, 99) == 0);
      if (bus.done === 1'b1)
        $display("[TB] op random -> sum=%h cout=%0d", bus.sum, bus.cout);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    repeat (W + 4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
